button_debouncer: RTL
=====================

# button_debouncer

Debounces one raw, asynchronous push-button input and produces a clean level plus single-cycle press and release pulses. It sits between the board pin and the edge-detection stage of the alarm-clock user interface. Its `btn_level` output is the signal that the edge detector consumes. With the optional repeat feature enabled, it also generates periodic press pulses while the button is held, which drives fast time-setting.

## Interface
Parameters:
- `DB_CYCLES`, default 1_000_000. Consecutive synchronized cycles a new level must hold before it is accepted (10 ms at 100 MHz). Legal range 2 to 2^24-1.
- `REPEAT_DELAY`, default 50_000_000. Cycles in PRESSED before the first repeat pulse. Used only with the repeat macro.
- `REPEAT_PERIOD`, default 10_000_000. Cycles between subsequent repeat pulses. Used only with the repeat macro.

Ports:
- `clk`  input  1  system clock; every flop is on its rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset).
- `btn_in`  input  1  raw button, asynchronous to `clk`, active-high.
- `btn_level`  output  1  debounced button level.
- `btn_press`  output  1  one-cycle pulse on accepted press; also on each repeat when the macro is enabled.
- `btn_release`  output  1  one-cycle pulse on accepted release.

## Operation
- Reset (`reset`=0 at a clock edge):
  - State goes to IDLE.
  - Both synchronizer flops, the counters and all outputs clear to 0.
- Synchronizer: two flops. `s2` is the synchronized input used by the FSM.
- Debounce counter `cnt`:
  - Width is `$clog2(DB_CYCLES+1)`.
  - It is zero-extended against `DB_CYCLES` and never wraps.
- FSM states and transitions:
  - IDLE: when `s2`=1, go to PRESS_WAIT and set `cnt`=1.
  - PRESS_WAIT, `s2`=0: go to IDLE and set `cnt`=0.
  - PRESS_WAIT, `s2`=1 and `cnt`==`DB_CYCLES`: go to PRESSED and register `btn_level`=1, `btn_press`=1.
  - PRESS_WAIT, otherwise: increment `cnt`.
  - PRESSED: when `s2`=0, go to RELEASE_WAIT and set `cnt`=1.
  - RELEASE_WAIT, `s2`=1: go back to PRESSED and set `cnt`=0. No pulse is issued and `btn_level` stays 1.
  - RELEASE_WAIT, `s2`=0 and `cnt`==`DB_CYCLES`: go to IDLE and register `btn_level`=0, `btn_release`=1.
  - RELEASE_WAIT, otherwise: increment `cnt`.
- Outputs:
  - `btn_press` and `btn_release` are registered and high for exactly one cycle. They are never high in the same cycle.
  - `btn_level` is high in PRESSED and RELEASE_WAIT only.
- Bounces shorter than `DB_CYCLES` synchronized cycles never change any output.
- A reset asserted mid-count, or while PRESSED, discards the in-progress count and any held state. No release pulse is emitted.

## Timing
- `btn_in` is sampled high by the first synchronizer flop at edge t0 and stays high. Then `btn_level` and `btn_press` are high after edge t0+`DB_CYCLES`+1. Latency is `DB_CYCLES`+2 edges.
- Release latency is symmetric: `btn_release` is high after edge t0+`DB_CYCLES`+1.
- Earliest possible press after a release: `DB_CYCLES`+2 cycles after leaving RELEASE_WAIT.

## Configuration
- Macro `BUTTON_DEBOUNCER_REPEAT_EN`.
- Defined:
  - A repeat counter `rpt` clears on entry to PRESSED from PRESS_WAIT.
  - `rpt` counts every cycle in PRESSED and freezes in RELEASE_WAIT.
  - It clears to 0 in IDLE and PRESS_WAIT.
  - `btn_press` pulses when `rpt` reaches `REPEAT_DELAY`. It then pulses every `REPEAT_PERIOD` cycles; `rpt` reloads to `REPEAT_DELAY`-`REPEAT_PERIOD` on each pulse.
  - A repeat pulse never coincides with `btn_release`.
- Undefined:
  - No repeat logic or parameters are used.
  - `btn_press` fires once per accepted press.

## Structure
- Package `debounce_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t`;
  - the default constants for `DB_CYCLES`, `REPEAT_DELAY` and `REPEAT_PERIOD`.
- Sub-module `sync_2ff`: a 2-flop synchronizer with synchronous active-low reset, reused by other pin inputs.
- The FSM, `cnt` and `rpt` stay in `button_debouncer`.

## Test plan
All scenarios use `DB_CYCLES`=4; the repeat scenario also uses `REPEAT_DELAY`=10 and `REPEAT_PERIOD`=3.
- Clean press: `btn_in` rises, first sampled at edge t0. Required: `btn_level`=1 and a one-cycle `btn_press` after edge t0+5; `btn_release` stays 0.
- Bounce: pulses 1-0-1-0 of 2 cycles each, then low. Required: all outputs stay 0 throughout.
- Release glitch: while PRESSED, drive `btn_in` low for 3 cycles, then high. Required: `btn_level` stays 1 and no pulses occur.
- Clean release: after a press, `btn_in` goes low at t1. Required: one `btn_release` pulse and `btn_level`=0 after edge t1+5.
- Reset mid-operation: assert `reset`=0 while in PRESSED. Required: next cycle all outputs are 0, state is IDLE and no pulse is emitted; the button, still held, is re-accepted 6 edges after `reset` returns to 1.
- Repeat (macro defined): hold the button 30 cycles after acceptance. Required: `btn_press` at acceptance, then at `rpt`=10, 13, 16 and so on.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  localparam int unsigned DB_CYCLES_DEF     = 1_000_000;
  localparam int unsigned REPEAT_DELAY_DEF  = 50_000_000;
  localparam int unsigned REPEAT_PERIOD_DEF = 10_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin, synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Shift the raw pin through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: clean level plus one-cycle press/release pulses.
// Optional auto-repeat of press pulses while held: BUTTON_DEBOUNCER_REPEAT_EN.
//
// state        | meaning
// IDLE         | button accepted as released, level 0
// PRESS_WAIT   | synchronized input high, counting toward acceptance
// PRESSED      | button accepted as pressed, level 1
// RELEASE_WAIT | synchronized input low, counting toward release
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  // cnt holds how many cycles the new level has already been seen; the
  // level is accepted on the cycle that makes that count DB_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_ONE    = RW'(1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RW-1:0] rpt_q;
`endif

  db_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          s2;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_in),
    .q_o   (s2)
  );

  // Debounce FSM with registered level and pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
          rpt_q <= '0;
`endif
          if (s2) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
          rpt_q <= '0;
`endif
          if (!s2) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
          if (rpt_q == RPT_LAST) begin
            press_q <= 1'b1;
            rpt_q   <= RPT_RELOAD;
          end else begin
            rpt_q <= rpt_q + RPT_ONE;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (s2) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
